pow2_seq_ctrl: RTL

POW2_SEQ_CTRL -- requirements
Module: pow2_seq_ctrl

---
 rtl/pow2_pkg.sv | 12 +
 rtl/pow2_stats.sv | 23 ++
 rtl/pow2_seq_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/pow2_pkg.sv
// Shared types and constants for the power-of-two sequential checker.
package pow2_pkg;

  localparam int POW2_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pow2_stats.sv
// Retired-result counters for pow2_seq_ctrl; only instantiated when
// POW2_SEQ_STATS_EN is defined.
module pow2_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        hit,
  output logic [15:0] tot_cnt,
  output logic [15:0] hit_cnt
);

  // Both counters wrap naturally at 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_cnt <= '0;
      hit_cnt <= '0;
    end else if (retire) begin
      tot_cnt <= tot_cnt + 16'd1;
      if (hit) hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pow2_seq_ctrl.sv
// Sequential power-of-two / trailing-zero checker with valid/ready handshakes.
// Define POW2_SEQ_STATS_EN to add the tot_cnt/hit_cnt statistics outputs.
module pow2_seq_ctrl
  import pow2_pkg::*;
#(
  parameter int W  = POW2_W_DEFAULT,
  localparam int LW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_is_pow2,
  output logic [LW-1:0] out_log2,
  output logic          busy
`ifdef POW2_SEQ_STATS_EN
  ,
  output logic [15:0]   tot_cnt,
  output logic [15:0]   hit_cnt
`endif
);

  state_t        state;
  logic [W-1:0]  sr;
  logic [LW-1:0] idx;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_is_pow2 <= 1'b0;
      out_log2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= in_data;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sr == '0) begin
            out_is_pow2 <= 1'b0;
            out_log2    <= '0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (sr[0]) begin
            // First set bit found: idx is the trailing-zero count, at most W-1.
            out_is_pow2 <= (sr == W'(1));
            out_log2    <= idx;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            sr  <= sr >> 1;
            idx <= idx + LW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_is_pow2 <= 1'b0;
            out_log2    <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POW2_SEQ_STATS_EN
  pow2_stats u_stats (
    .clk     (clk),
    .rst     (rst),
    .retire  (out_valid & out_ready),
    .hit     (out_is_pow2),
    .tot_cnt (tot_cnt),
    .hit_cnt (hit_cnt)
  );
`endif

endmodule
